gppcu_writeback_arb: RTL and testbench
======================================

GPPCU_WRITEBACK_ARB -- requirements
Module: gppcu_writeback_arb

Interface
REQ-001 Parameter NUMREG, default 32, number of architectural registers; register index width RBW = bit_fit(NUMREG-1).
REQ-002 Parameter DW, default 32, result data width.
REQ-003 Parameter DEPTH, default 4, ALU result FIFO entries (power of two, >=2).
REQ-004 iACLK  in  1  sole clock, all state rising-edge.
REQ-005 iRST  in  1  asynchronous, active-high reset.
REQ-006 iALU_VALID / iALU_REG / iALU_DATA  in  1 / RBW / DW  ALU result; no backpressure; push accepted unconditionally.
REQ-007 oALU_STALL  out  1  issue must hold ALU dispatch.
REQ-008 iLSU_VALID / iLSU_REG / iLSU_DATA  in  1 / RBW / DW  load result; valid/ready handshake.
REQ-009 oLSU_READY  out  1  load result consumed this cycle.
REQ-010 oWRREG / oWRDATA / oWRREG_VALID  out  RBW / DW / 1  single register-file write port; oWRREG/oWRREG_VALID also release the scoreboard occupancy bit in the stall generator.
REQ-011 oOVERFLOW  out  1  sticky ALU FIFO overflow flag.

Function
REQ-012 ALU results enter a DEPTH-entry FIFO; count range 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-013 oALU_STALL = (count >= DEPTH-1), combinational from count only.
REQ-014 Sources per cycle: F = FIFO head (count>0), L = iLSU_VALID; at most one grant per cycle.
REQ-015 Only one of F/L requesting: that one is granted.
REQ-016 Both requesting: round-robin; 1-bit last_grant flag; grant goes to the source not granted last; last_grant updates only on a grant.
REQ-017 oLSU_READY = iLSU_VALID && L granted; LSU transfer occurs iff iLSU_VALID && oLSU_READY; LSU holds REG/DATA stable until then.
REQ-018 Granted entry is registered into oWRREG/oWRDATA, oWRREG_VALID = 1 on the next cycle; with no grant, oWRREG_VALID = 0 and oWRREG/oWRDATA hold their last values.
REQ-019 Latency: LSU transfer to oWRREG_VALID = 1 cycle; ALU push to oWRREG_VALID >= 2 cycles (FIFO write, then grant/register) unless REQ-027 applies.
REQ-020 Simultaneous ALU push and FIFO pop: both occur; count unchanged; legal at count==DEPTH.
REQ-021 Push at count==DEPTH without a pop in the same cycle: result dropped, FIFO unchanged, oOVERFLOW set to 1 until reset.
REQ-022 Push into empty FIFO: entry becomes eligible for grant the following cycle, not the push cycle.
REQ-023 FIFO order preserved; no reordering between ALU results; no ordering guarantee between ALU and LSU results.
REQ-024 No write suppression for any index (register 0 included); filtering is the register file's job.

Reset
REQ-025 While iRST=1, asynchronously: count=0, pointers=0, last_grant=LSU (FIFO wins first contention), oWRREG_VALID=0, oWRREG=0, oWRDATA=0, oOVERFLOW=0, oLSU_READY=0, oALU_STALL=0.
REQ-026 Reset mid-operation discards all FIFO contents and any in-flight output; inputs sampled in the reset-release cycle follow normal rules.

Configuration
REQ-027 Macro GPPCU_WB_BYPASS_EN defined: when count==0 and iALU_VALID, the ALU result is a third-priority-free direct request treated as F in the same cycle; if granted it skips the FIFO (no push) and oWRREG_VALID rises next cycle (latency 1); if not granted it is pushed normally.
REQ-028 GPPCU_WB_BYPASS_EN undefined: every ALU result goes through the FIFO; REQ-019/REQ-022 latencies apply unchanged.

Verification
REQ-029 Single ALU push reg=5 data=0xDEADBEEF, idle LSU -> oWRREG_VALID=1, oWRREG=5, oWRDATA=0xDEADBEEF at cycle+2 (cycle+1 with GPPCU_WB_BYPASS_EN), exactly one pulse.
REQ-030 LSU valid reg=7 data=0x1234 with FIFO empty -> oLSU_READY=1 same cycle; write of reg 7 next cycle.
REQ-031 FIFO holds 3 ALU entries, LSU valid continuously with 2 results -> writes alternate FIFO,LSU,FIFO,LSU,FIFO after reset-time last_grant=LSU.
REQ-032 DEPTH=4, 4 pushes with LSU hogging blocked-free grants paused (hold FIFO via LSU contention) -> oALU_STALL=1 at count 3; 5th push at count 4 without pop -> oOVERFLOW=1, dropped entry never written.
REQ-033 Push and pop in same cycle at count 4 -> count stays 4, oOVERFLOW stays 0, order intact.
REQ-034 Assert iRST with 2 FIFO entries and oWRREG_VALID=1 -> all outputs 0 immediately; after release no stale write appears.

Source files
------------

// File: rtl/gppcu_writeback_arb.sv
// Writeback arbiter: ALU result FIFO and LSU handshake share one RF port.
// Define GPPCU_WB_BYPASS_EN to let an ALU result skip an empty FIFO.
module gppcu_writeback_arb #(
  parameter int NUMREG = 32,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  localparam int RBW = (NUMREG > 1) ? $clog2(NUMREG) : 1
) (
  input  logic           iACLK,
  input  logic           iRST,
  input  logic           iALU_VALID,
  input  logic [RBW-1:0] iALU_REG,
  input  logic [DW-1:0]  iALU_DATA,
  output logic           oALU_STALL,
  input  logic           iLSU_VALID,
  input  logic [RBW-1:0] iLSU_REG,
  input  logic [DW-1:0]  iLSU_DATA,
  output logic           oLSU_READY,
  output logic [RBW-1:0] oWRREG,
  output logic [DW-1:0]  oWRDATA,
  output logic           oWRREG_VALID,
  output logic           oOVERFLOW
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_C  = (PW+1)'(DEPTH);
  localparam logic [PW:0] STALL_C = (PW+1)'(DEPTH - 1);

  logic [PW:0]         count;
  logic [PW-1:0]       wp;
  logic [PW-1:0]       rp;
  logic                last_lsu;
  logic [RBW+DW-1:0]   mem [DEPTH];
  logic [RBW+DW-1:0]   head;

  logic byp;
  logic f_req;
  logic gnt_f;
  logic gnt_l;
  logic pop;
  logic push_req;
  logic drop;
  logic push;

`ifdef GPPCU_WB_BYPASS_EN
  assign byp = (count == '0) && iALU_VALID;
`else
  assign byp = 1'b0;
`endif

  // byp implies an empty FIFO, so a FIFO grant without byp is a real pop
  assign f_req    = (count != '0) || byp;
  assign gnt_f    = f_req && (!iLSU_VALID || last_lsu);
  assign gnt_l    = iLSU_VALID && !gnt_f;
  assign pop      = gnt_f && !byp;
  assign push_req = iALU_VALID && !(gnt_f && byp);
  assign drop     = push_req && (count == FULL_C) && !pop;
  assign push     = push_req && !drop;

  assign head       = mem[rp];
  assign oLSU_READY = gnt_l && !iRST;
  assign oALU_STALL = count >= STALL_C;

  always_ff @(posedge iACLK) begin
    if (push) mem[wp] <= {iALU_REG, iALU_DATA};
  end

  always_ff @(posedge iACLK or posedge iRST) begin
    if (iRST) begin
      count        <= '0;
      wp           <= '0;
      rp           <= '0;
      last_lsu     <= 1'b1;
      oWRREG       <= '0;
      oWRDATA      <= '0;
      oWRREG_VALID <= 1'b0;
      oOVERFLOW    <= 1'b0;
    end else begin
      unique case (1'b1)
        gnt_f: begin
          oWRREG_VALID <= 1'b1;
          last_lsu     <= 1'b0;
          {oWRREG, oWRDATA} <= byp ? {iALU_REG, iALU_DATA} : head;
        end
        gnt_l: begin
          oWRREG_VALID <= 1'b1;
          last_lsu     <= 1'b1;
          oWRREG       <= iLSU_REG;
          oWRDATA      <= iLSU_DATA;
        end
        default: oWRREG_VALID <= 1'b0;
      endcase
      if (drop) oOVERFLOW <= 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gppcu_writeback_arb.sv
// Randomised and directed bench for gppcu_writeback_arb.
// Reference model: queue-based FIFO plus round-robin flag.
module tb_gppcu_writeback_arb;

  localparam int NUMREG = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int RBW = $clog2(NUMREG);
`ifdef GPPCU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [RBW-1:0] r;
    logic [DW-1:0]  d;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           alu_valid = 1'b0;
  logic [RBW-1:0] alu_reg = '0;
  logic [DW-1:0]  alu_data = '0;
  logic           lsu_valid = 1'b0;
  logic [RBW-1:0] lsu_reg = '0;
  logic [DW-1:0]  lsu_data = '0;
  logic           alu_stall;
  logic           lsu_ready;
  logic [RBW-1:0] wr_reg;
  logic [DW-1:0]  wr_data;
  logic           wr_valid;
  logic           overflow;

  int checks = 0;
  int errors = 0;

  gppcu_writeback_arb #(
    .NUMREG(NUMREG),
    .DW(DW),
    .DEPTH(DEPTH)
  ) dut (
    .iACLK(clk),
    .iRST(rst),
    .iALU_VALID(alu_valid),
    .iALU_REG(alu_reg),
    .iALU_DATA(alu_data),
    .oALU_STALL(alu_stall),
    .iLSU_VALID(lsu_valid),
    .iLSU_REG(lsu_reg),
    .iLSU_DATA(lsu_data),
    .oLSU_READY(lsu_ready),
    .oWRREG(wr_reg),
    .oWRDATA(wr_data),
    .oWRREG_VALID(wr_valid),
    .oOVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  ent_t           m_q[$];
  bit             m_last_lsu;
  bit             m_val;
  logic [RBW-1:0] m_reg;
  logic [DW-1:0]  m_data;
  bit             m_ovf;
  bit             m_drop;
  logic [DW-1:0]  m_drop_data;

  function automatic bit m_gnt_f();
    bit f;
    f = (m_q.size() > 0) || (BYP && alu_valid);
    if (!f) return 1'b0;
    if (!lsu_valid) return 1'b1;
    return m_last_lsu;
  endfunction

  function automatic bit m_gnt_l();
    return lsu_valid && !m_gnt_f();
  endfunction

  function automatic bit m_stall();
    return m_q.size() >= DEPTH - 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last_lsu = 1'b1;
    m_val = 1'b0;
    m_reg = '0;
    m_data = '0;
    m_ovf = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic model_commit();
    int n;
    bit gf, gl, tb;
    ent_t e;
    n = m_q.size();
    gf = m_gnt_f();
    gl = m_gnt_l();
    tb = gf && (n == 0);
    m_drop = 1'b0;
    if (gf) begin
      m_val = 1'b1;
      m_last_lsu = 1'b0;
      if (tb) begin
        m_reg = alu_reg;
        m_data = alu_data;
      end else begin
        e = m_q.pop_front();
        m_reg = e.r;
        m_data = e.d;
      end
    end else if (gl) begin
      m_val = 1'b1;
      m_last_lsu = 1'b1;
      m_reg = lsu_reg;
      m_data = lsu_data;
    end else begin
      m_val = 1'b0;
    end
    if (alu_valid && !tb) begin
      if (n == DEPTH && !gf) begin
        m_ovf = 1'b1;
        m_drop = 1'b1;
        m_drop_data = alu_data;
      end else begin
        e.r = alu_reg;
        e.d = alu_data;
        m_q.push_back(e);
      end
    end
  endtask

  task automatic clk_step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    #12;
    checks++;
    if ({wr_valid, wr_reg, wr_data, overflow} !== '0)
      $display("FAIL reset_out: got %0b/%0h/%0h/%0b expected 0",
               wr_valid, wr_reg, wr_data, overflow);
    checks++;
    if ({lsu_ready, alu_stall} !== 2'b00)
      $display("FAIL reset_ready_stall: got %0b%0b expected 00",
               lsu_ready, alu_stall);
    if ({wr_valid, wr_reg, wr_data, overflow, lsu_ready, alu_stall} !== '0)
      errors++;
    do_reset();
  endtask

  task automatic test_single_alu();
    int hits;
    bit exp;
    hits = 0;
    alu_valid = 1'b1;
    alu_reg = RBW'(5);
    alu_data = 32'hDEADBEEF;
    clk_step();
    drive_idle();
    for (int i = 1; i <= 4; i++) begin
      exp = (i == (BYP ? 1 : 2));
      checks++;
      if (wr_valid !== exp) begin
        errors++;
        $display("FAIL single_alu_valid c%0d: got %0b expected %0b",
                 i, wr_valid, exp);
      end
      if (wr_valid === 1'b1) begin
        hits++;
        checks++;
        if (wr_reg !== RBW'(5) || wr_data !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL single_alu_data: got %0d/%0h expected 5/deadbeef",
                   wr_reg, wr_data);
        end
      end
      clk_step();
    end
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL single_alu_pulses: got %0d expected 1", hits);
    end
  endtask

  task automatic test_lsu_single();
    lsu_valid = 1'b1;
    lsu_reg = RBW'(7);
    lsu_data = 32'h1234;
    #1;
    checks++;
    if (lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL lsu_ready: got %0b expected 1", lsu_ready);
    end
    clk_step();
    drive_idle();
    checks++;
    if (wr_valid !== 1'b1 || wr_reg !== RBW'(7) || wr_data !== 32'h1234) begin
      errors++;
      $display("FAIL lsu_write: got %0b/%0d/%0h expected 1/7/1234",
               wr_valid, wr_reg, wr_data);
    end
    clk_step();
    checks++;
    if (wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsu_one_pulse: got %0b expected 0", wr_valid);
    end
  endtask

  task automatic test_alternate();
    ent_t got[$];
    ent_t exp[5];
    ent_t e;
    int li;
    logic rdy;
    do_reset();
    li = 0;
    exp[0] = '{RBW'(1), 32'hA0000000};
    exp[1] = '{RBW'(11), 32'hB0000000};
    exp[2] = '{RBW'(2), 32'hA0000001};
    exp[3] = '{RBW'(12), 32'hB0000001};
    exp[4] = '{RBW'(3), 32'hA0000002};
    for (int c = 0; c < 10; c++) begin
      alu_valid = (c < 3);
      alu_reg = RBW'(c + 1);
      alu_data = 32'hA0000000 + DW'(c);
      lsu_valid = (c >= 1) && (li < 2);
      lsu_reg = RBW'(11 + li);
      lsu_data = 32'hB0000000 + DW'(li);
      #1;
      rdy = lsu_ready;
      checks++;
      if (rdy !== m_gnt_l()) begin
        errors++;
        $display("FAIL alt_ready c%0d: got %0b expected %0b", c, rdy, m_gnt_l());
      end
      clk_step();
      if (rdy === 1'b1) li++;
      if (wr_valid === 1'b1) begin
        e.r = wr_reg;
        e.d = wr_data;
        got.push_back(e);
      end
    end
    drive_idle();
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL alt_count: got %0d expected 5", got.size());
    end
    if (!BYP || got.size() == 5) begin
      for (int i = 0; i < 5 && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL alt_order w%0d: got %0d/%0h expected %0d/%0h",
                   i, got[i].r, got[i].d, exp[i].r, exp[i].d);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int li;
    bit seen_drop;
    logic [DW-1:0] dropped[$];
    do_reset();
    li = 0;
    seen_drop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      alu_valid = (c < 12);
      alu_reg = RBW'(c);
      alu_data = 32'hC0000000 + DW'(c);
      lsu_valid = (c < 12);
      lsu_reg = RBW'(20 + (li % 8));
      lsu_data = 32'hD0000000 + DW'(li);
      #1;
      checks++;
      if (alu_stall !== m_stall() || lsu_ready !== m_gnt_l()) begin
        errors++;
        $display("FAIL ovf_comb c%0d: got stall=%0b rdy=%0b expected %0b %0b",
                 c, alu_stall, lsu_ready, m_stall(), m_gnt_l());
      end
      if (lsu_ready === 1'b1) li++;
      clk_step();
      if (m_drop) dropped.push_back(m_drop_data);
      checks++;
      if (wr_valid !== m_val || overflow !== m_ovf ||
          (m_val && (wr_reg !== m_reg || wr_data !== m_data))) begin
        errors++;
        $display("FAIL ovf_out c%0d: got %0b/%0h/%0b expected %0b/%0h/%0b",
                 c, wr_valid, wr_data, overflow, m_val, m_data, m_ovf);
      end
      foreach (dropped[k])
        if (wr_valid === 1'b1 && wr_data === dropped[k]) seen_drop = 1'b1;
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %0b expected 1", overflow);
    end
    checks++;
    if (seen_drop) begin
      errors++;
      $display("FAIL ovf_dropped_written: got 1 expected 0");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1'b1;
      alu_reg = RBW'(c);
      alu_data = 32'hE0000000 + DW'(c);
      lsu_valid = 1'b1;
      lsu_reg = RBW'(30);
      lsu_data = 32'hF0000000 + DW'(c);
      clk_step();
    end
    checks++;
    if (wr_valid !== 1'b1 || m_q.size() != 2) begin
      errors++;
      $display("FAIL mid_setup: got valid=%0b expected 1", wr_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_valid, wr_reg, wr_data, overflow, lsu_ready, alu_stall} !== '0) begin
      errors++;
      $display("FAIL mid_reset_out: got %0b/%0h/%0h/%0b/%0b expected 0",
               wr_valid, wr_reg, wr_data, overflow, lsu_ready);
    end
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      clk_step();
      checks++;
      if (wr_valid !== 1'b0 || alu_stall !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale c%0d: got valid=%0b stall=%0b expected 0 0",
                 c, wr_valid, alu_stall);
      end
    end
  endtask

  task automatic test_random();
    bit pend;
    pend = 1'b0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (alu_stall === 1'b1)
        alu_valid = ($urandom_range(0, 99) < 8);
      else
        alu_valid = ($urandom_range(0, 99) < 45);
      alu_reg = RBW'($urandom);
      alu_data = $urandom;
      if (!pend) begin
        pend = ($urandom_range(0, 99) < 50);
        lsu_reg = RBW'($urandom);
        lsu_data = $urandom;
      end
      lsu_valid = pend;
      #1;
      checks++;
      if (alu_stall !== m_stall() || lsu_ready !== m_gnt_l()) begin
        errors++;
        $display("FAIL rnd_comb c%0d: got stall=%0b rdy=%0b expected %0b %0b",
                 c, alu_stall, lsu_ready, m_stall(), m_gnt_l());
      end
      if (lsu_ready === 1'b1) pend = 1'b0;
      clk_step();
      checks++;
      if (wr_valid !== m_val || wr_reg !== m_reg || wr_data !== m_data ||
          overflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_out c%0d: got %0b/%0d/%0h/%0b expected %0b/%0d/%0h/%0b",
                 c, wr_valid, wr_reg, wr_data, overflow,
                 m_val, m_reg, m_data, m_ovf);
      end
    end
    drive_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_alu();
    test_lsu_single();
    test_alternate();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
